// File: rtl/big_sm_template.sv
// DDR3 command-sequencing FSM: tracks device state, drives registered CS/RAS/CAS/WE.
// Latency: pins change on the same edge as the state register. No backpressure; requests are levels.
// Optional power-down states are enabled by defining POWER_DOWN_EN.
module big_sm_template #(
    parameter int T_RFC   = 8,
    parameter int T_RCD   = 3,
    parameter int T_BURST = 4,
    parameter int T_RP    = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ZQCL,
    input  logic MRS,
    input  logic SRE,
    input  logic SRX,
    input  logic REF,
    input  logic PDE,
    input  logic PDX,
    input  logic ACT,
    input  logic WRITE,
    input  logic READ,
    input  logic WRITE_AP,
    input  logic READ_AP,
    input  logic PRE,
    input  logic CKE,
    output logic CS,
    output logic RAS,
    output logic CAS,
    output logic WE
);

    typedef enum logic [4:0] {
        POWER_ON             = 5'd0,
        RESET_PROCEDURE      = 5'd1,
        INITIALIZATION       = 5'd2,
        ZQ_CALIBRATION       = 5'd3,
        IDLE                 = 5'd4,
        WRITE_LEVELING       = 5'd5,
        SELF_REFRESH         = 5'd6,
        REFRESHING           = 5'd7,
        PRECHARGE_POWER_DOWN = 5'd8,
        ACTIVATING           = 5'd9,
        BANK_ACTIVE          = 5'd10,
        ACTIVE_POWER_DOWN    = 5'd11,
        WRITING              = 5'd12,
        READING              = 5'd13,
        WRITING_AP           = 5'd14,
        READING_AP           = 5'd15,
        PRECHARGING          = 5'd16
    } state_t;

    localparam logic [7:0] RFC_LD   = 8'(T_RFC - 1);
    localparam logic [7:0] RCD_LD   = 8'(T_RCD - 1);
    localparam logic [7:0] BURST_LD = 8'(T_BURST - 1);
    localparam logic [7:0] RP_LD    = 8'(T_RP - 1);

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;

    state_t     state;
    state_t     nxt;
    logic [7:0] cnt;
    logic [3:0] cmd;

    assign {CS, RAS, CAS, WE} = cmd;

`ifndef POWER_DOWN_EN
    logic unused_pd;
    assign unused_pd = PDE ^ PDX;
`endif

    // Command issued on the first cycle of a freshly entered state.
    function automatic logic [3:0] entry_cmd(input state_t s);
        case (s)
            ZQ_CALIBRATION:              entry_cmd = 4'b0110;
            WRITE_LEVELING:              entry_cmd = 4'b0000;
            REFRESHING, SELF_REFRESH:    entry_cmd = 4'b0001;
            ACTIVATING:                  entry_cmd = 4'b0011;
            WRITING, WRITING_AP:         entry_cmd = 4'b0100;
            READING, READING_AP:         entry_cmd = 4'b0101;
            PRECHARGING:                 entry_cmd = 4'b0010;
            POWER_ON, RESET_PROCEDURE,
            PRECHARGE_POWER_DOWN,
            ACTIVE_POWER_DOWN:           entry_cmd = CMD_DESEL;
            default:                     entry_cmd = CMD_NOP;
        endcase
    endfunction

    function automatic logic [3:0] hold_cmd(input state_t s);
        case (s)
            POWER_ON, RESET_PROCEDURE, SELF_REFRESH,
            PRECHARGE_POWER_DOWN, ACTIVE_POWER_DOWN: hold_cmd = CMD_DESEL;
            default:                                 hold_cmd = CMD_NOP;
        endcase
    endfunction

    function automatic logic [7:0] load_val(input state_t s);
        case (s)
            REFRESHING:                                 load_val = RFC_LD;
            ACTIVATING:                                 load_val = RCD_LD;
            WRITING, READING, WRITING_AP, READING_AP:   load_val = BURST_LD;
            PRECHARGING:                                load_val = RP_LD;
            default:                                    load_val = 8'd0;
        endcase
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            POWER_ON:        nxt = RESET_PROCEDURE;
            RESET_PROCEDURE: nxt = INITIALIZATION;
            INITIALIZATION:  if (ZQCL) nxt = ZQ_CALIBRATION;
            ZQ_CALIBRATION:  if (!ZQCL) nxt = IDLE;
            IDLE: begin
                if (REF)      nxt = REFRESHING;
                else if (SRE) nxt = SELF_REFRESH;
`ifdef POWER_DOWN_EN
                else if (PDE) nxt = PRECHARGE_POWER_DOWN;
`endif
                else if (MRS) nxt = WRITE_LEVELING;
                else if (ACT) nxt = ACTIVATING;
            end
            WRITE_LEVELING:  if (!MRS) nxt = IDLE;
            SELF_REFRESH:    if (SRX && CKE) nxt = IDLE;
            REFRESHING:      if (cnt == 8'd0) nxt = IDLE;
            ACTIVATING:      if (cnt == 8'd0) nxt = BANK_ACTIVE;
            BANK_ACTIVE: begin
                if (PRE)           nxt = PRECHARGING;
                else if (WRITE_AP) nxt = WRITING_AP;
                else if (READ_AP)  nxt = READING_AP;
                else if (WRITE)    nxt = WRITING;
                else if (READ)     nxt = READING;
`ifdef POWER_DOWN_EN
                else if (PDE)      nxt = ACTIVE_POWER_DOWN;
`endif
            end
            WRITING, READING:       if (cnt == 8'd0) nxt = BANK_ACTIVE;
            WRITING_AP, READING_AP: if (cnt == 8'd0) nxt = PRECHARGING;
            PRECHARGING:            if (cnt == 8'd0) nxt = IDLE;
`ifdef POWER_DOWN_EN
            PRECHARGE_POWER_DOWN:   if (PDX && CKE) nxt = IDLE;
            ACTIVE_POWER_DOWN:      if (PDX && CKE) nxt = BANK_ACTIVE;
`endif
            default:                nxt = POWER_ON;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= POWER_ON;
            cnt   <= 8'd0;
            cmd   <= CMD_DESEL;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                cmd <= entry_cmd(nxt);
                cnt <= load_val(nxt);
            end else begin
                cmd <= hold_cmd(nxt);
                cnt <= (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_big_sm_template.sv
// Directed bench for the DDR3 command FSM; checks state code and command pins per cycle.
module tb_big_sm_template;

    logic CLK, RESET;
    logic ZQCL, MRS, SRE, SRX, REF, PDE, PDX, ACT;
    logic WRITE, READ, WRITE_AP, READ_AP, PRE, CKE;
    logic CS, RAS, CAS, WE;
    logic [3:0] pins;
    int checks = 0;
    int fails  = 0;

    assign pins = {CS, RAS, CAS, WE};

    big_sm_template dut (
        .CLK(CLK), .RESET(RESET), .ZQCL(ZQCL), .MRS(MRS), .SRE(SRE), .SRX(SRX),
        .REF(REF), .PDE(PDE), .PDX(PDX), .ACT(ACT), .WRITE(WRITE), .READ(READ),
        .WRITE_AP(WRITE_AP), .READ_AP(READ_AP), .PRE(PRE), .CKE(CKE),
        .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        {ZQCL, MRS, SRE, SRX, REF, PDE, PDX, ACT} = '0;
        {WRITE, READ, WRITE_AP, READ_AP, PRE, CKE} = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET = 1'b1;
        #2 RESET = 1'b0;
        tick(); tick();
        checks++;
        if (dut.state !== 5'd0 || pins !== 4'b1111) begin
            fails++;
            $display("FAIL reset_hold state=%0d pins=%b expected state=0 pins=1111", dut.state, pins);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd1 || pins !== 4'b1111) begin
            fails++;
            $display("FAIL reset_proc state=%0d pins=%b expected state=1 pins=1111", dut.state, pins);
        end
        tick();
        checks++;
        if (dut.state !== 5'd2 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL init state=%0d pins=%b expected state=2 pins=0111", dut.state, pins);
        end
    endtask

    task automatic test_zq();
        ZQCL = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd3 || pins !== 4'b0110) begin
            fails++;
            $display("FAIL zq_entry state=%0d pins=%b expected state=3 pins=0110", dut.state, pins);
        end
        ZQCL = 1'b0;
        tick();
        checks++;
        if (dut.state !== 5'd4 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL zq_exit state=%0d pins=%b expected state=4 pins=0111", dut.state, pins);
        end
    endtask

    task automatic test_mrs();
        MRS = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd5 || pins !== 4'b0000) begin
            fails++;
            $display("FAIL mrs_entry state=%0d pins=%b expected state=5 pins=0000", dut.state, pins);
        end
        tick();
        checks++;
        if (dut.state !== 5'd5 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL mrs_hold state=%0d pins=%b expected state=5 pins=0111", dut.state, pins);
        end
        MRS = 1'b0;
        tick();
        checks++;
        if (dut.state !== 5'd4 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL mrs_exit state=%0d pins=%b expected state=4 pins=0111", dut.state, pins);
        end
    endtask

    // Enter Refreshing from Idle and count out its eight cycles.
    task automatic run_refresh(input string name);
        tick();
        checks++;
        if (dut.state !== 5'd7 || pins !== 4'b0001) begin
            fails++;
            $display("FAIL %s_entry state=%0d pins=%b expected state=7 pins=0001", name, dut.state, pins);
        end
        clear_inputs();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (dut.state !== 5'd7 || pins !== 4'b0111) begin
                fails++;
                $display("FAIL %s_hold%0d state=%0d pins=%b expected state=7 pins=0111", name, i, dut.state, pins);
            end
        end
        tick();
        checks++;
        if (dut.state !== 5'd4 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL %s_exit state=%0d pins=%b expected state=4 pins=0111", name, dut.state, pins);
        end
    endtask

    task automatic test_refresh();
        REF = 1'b1;
        run_refresh("ref");
        REF = 1'b1;
        ACT = 1'b1;
        run_refresh("ref_prio");
    endtask

    task automatic go_bank_active(input string name);
        ACT = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd9 || pins !== 4'b0011) begin
            fails++;
            $display("FAIL %s_act state=%0d pins=%b expected state=9 pins=0011", name, dut.state, pins);
        end
        ACT = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dut.state !== 5'd10 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL %s_bank state=%0d pins=%b expected state=10 pins=0111", name, dut.state, pins);
        end
    endtask

    task automatic test_act_write_pre();
        go_bank_active("awp");
        WRITE = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd12 || pins !== 4'b0100) begin
            fails++;
            $display("FAIL wr_entry state=%0d pins=%b expected state=12 pins=0100", dut.state, pins);
        end
        WRITE = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dut.state !== 5'd12 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL wr_last state=%0d pins=%b expected state=12 pins=0111", dut.state, pins);
        end
        tick();
        checks++;
        if (dut.state !== 5'd10) begin
            fails++;
            $display("FAIL wr_exit state=%0d expected state=10", dut.state);
        end
        PRE = 1'b1;
        WRITE = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd16 || pins !== 4'b0010) begin
            fails++;
            $display("FAIL pre_entry state=%0d pins=%b expected state=16 pins=0010", dut.state, pins);
        end
        PRE = 1'b0;
        WRITE = 1'b0;
        tick(); tick();
        checks++;
        if (dut.state !== 5'd16) begin
            fails++;
            $display("FAIL pre_last state=%0d expected state=16", dut.state);
        end
        tick();
        checks++;
        if (dut.state !== 5'd4 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL pre_exit state=%0d pins=%b expected state=4 pins=0111", dut.state, pins);
        end
    endtask

    task automatic test_back_to_back();
        go_bank_active("b2b");
        WRITE = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        checks++;
        if (dut.state !== 5'd10) begin
            fails++;
            $display("FAIL b2b_return state=%0d expected state=10", dut.state);
        end
        tick();
        checks++;
        if (dut.state !== 5'd12 || pins !== 4'b0100) begin
            fails++;
            $display("FAIL b2b_rewrite state=%0d pins=%b expected state=12 pins=0100", dut.state, pins);
        end
        WRITE = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (dut.state !== 5'd10) begin
            fails++;
            $display("FAIL b2b_done state=%0d expected state=10", dut.state);
        end
    endtask

    task automatic test_read_ap();
        READ_AP = 1'b1;
        READ = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd15 || pins !== 4'b0101) begin
            fails++;
            $display("FAIL rdap_entry state=%0d pins=%b expected state=15 pins=0101", dut.state, pins);
        end
        READ_AP = 1'b0;
        READ = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dut.state !== 5'd15) begin
            fails++;
            $display("FAIL rdap_last state=%0d expected state=15", dut.state);
        end
        tick();
        checks++;
        if (dut.state !== 5'd16 || pins !== 4'b0010) begin
            fails++;
            $display("FAIL rdap_pre state=%0d pins=%b expected state=16 pins=0010", dut.state, pins);
        end
        tick(); tick(); tick();
        checks++;
        if (dut.state !== 5'd4) begin
            fails++;
            $display("FAIL rdap_idle state=%0d expected state=4", dut.state);
        end
    endtask

    task automatic test_self_refresh();
        SRE = 1'b1;
        MRS = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd6 || pins !== 4'b0001) begin
            fails++;
            $display("FAIL sre_entry state=%0d pins=%b expected state=6 pins=0001", dut.state, pins);
        end
        clear_inputs();
        SRX = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd6 || pins !== 4'b1111) begin
            fails++;
            $display("FAIL srx_nocke state=%0d pins=%b expected state=6 pins=1111", dut.state, pins);
        end
        CKE = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd4 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL srx_exit state=%0d pins=%b expected state=4 pins=0111", dut.state, pins);
        end
        clear_inputs();
    endtask

    task automatic test_power_down();
`ifdef POWER_DOWN_EN
        PDE = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd8 || pins !== 4'b1111) begin
            fails++;
            $display("FAIL ppd_entry state=%0d pins=%b expected state=8 pins=1111", dut.state, pins);
        end
        PDE = 1'b0;
        PDX = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd8 || pins !== 4'b1111) begin
            fails++;
            $display("FAIL ppd_nocke state=%0d pins=%b expected state=8 pins=1111", dut.state, pins);
        end
        CKE = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd4 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL ppd_exit state=%0d pins=%b expected state=4 pins=0111", dut.state, pins);
        end
`else
        PDE = 1'b1;
        ACT = 1'b1;
        tick();
        checks++;
        if (dut.state !== 5'd9 || pins !== 4'b0011) begin
            fails++;
            $display("FAIL pde_ignored state=%0d pins=%b expected state=9 pins=0011", dut.state, pins);
        end
        clear_inputs();
        tick(); tick(); tick();
        PRE = 1'b1;
        tick();
        PRE = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dut.state !== 5'd4) begin
            fails++;
            $display("FAIL pde_back_idle state=%0d expected state=4", dut.state);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        go_bank_active("rst");
        WRITE = 1'b1;
        tick();
        tick();
        WRITE = 1'b0;
        #2 RESET = 1'b0;
        #1;
        checks++;
        if (dut.state !== 5'd0 || pins !== 4'b1111) begin
            fails++;
            $display("FAIL reset_async state=%0d pins=%b expected state=0 pins=1111", dut.state, pins);
        end
        tick();
        RESET = 1'b1;
        tick(); tick();
        checks++;
        if (dut.state !== 5'd2 || pins !== 4'b0111) begin
            fails++;
            $display("FAIL reset_reinit state=%0d pins=%b expected state=2 pins=0111", dut.state, pins);
        end
    endtask

    initial begin
        test_reset();
        test_zq();
        test_mrs();
        test_refresh();
        test_act_write_pre();
        test_back_to_back();
        PRE = 1'b1;
        tick();
        PRE = 1'b0;
        tick(); tick(); tick();
        go_bank_active("rdap");
        test_read_ap();
        test_self_refresh();
        test_power_down();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
